// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter/sequencer.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int NPORTS_DEF = 2;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int PORT_W_DEF = $clog2(NPORTS_DEF);

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant with a registered last-grant pointer advanced on accept.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NPORTS = NPORTS_DEF,
    parameter int PW     = port_w(NPORTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              advance,
    output logic [NPORTS-1:0] gnt,
    output logic [PW-1:0]     gnt_idx
);

    logic [PW-1:0] last_q;
    logic          found;
    int            idx;

    // Search starts just past the last winner so every port gets a turn.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = (int'(last_q) + i) % NPORTS;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PW'(NPORTS - 1);
        end else if (advance) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer issuing one SRAM access every other cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NPORTS = NPORTS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    output logic [NPORTS-1:0]        req_ready,
    input  logic [NPORTS-1:0]        req_wen,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    output logic [NPORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     sram_en,
    output logic                     sram_wen,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata
);

    localparam int PW = port_w(NPORTS);

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NPORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic              is_read_q, is_read_d;

    logic [NPORTS-1:0] gnt;
    logic [PW-1:0]     gnt_idx;
    logic              accept_window;
    logic              accept;
    logic              read_capture;

    assign accept_window = (state_q == IDLE) || (state_q == CAPTURE);
    assign req_ready     = (accept_window && !reset) ? gnt : '0;
    assign accept        = |(req_valid & req_ready);
    assign read_capture  = (state_q == CAPTURE) && is_read_q;

    rr_arbiter #(.NPORTS(NPORTS), .PW(PW)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        owner_d     = owner_q;
        is_read_d   = is_read_q;
        case (state_q)
            IDLE, CAPTURE: begin
                if (read_capture) begin
                    rdata_d = sram_rdata;
                end
                if (accept) begin
                    state_d   = ACCESS;
                    en_d      = 1'b1;
                    wen_d     = req_wen[gnt_idx];
                    addr_d    = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[gnt_idx*DATA_W +: DATA_W];
                    owner_d   = gnt_idx;
                    is_read_d = !req_wen[gnt_idx];
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d              = CAPTURE;
                rsp_valid_d[owner_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            owner_q     <= '0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            owner_q     <= owner_d;
            is_read_q   <= is_read_d;
        end
    end

    assign sram_en    = en_q;
    assign sram_wen   = wen_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rsp_valid  = rsp_valid_q;
    // The wrapper's registered read port drives the response during CAPTURE;
    // rdata_q then holds that word until the next read completes.
    assign rsp_rdata  = read_capture ? sram_rdata : rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a transaction-level reference model.
module tb_sram_arbiter;

    localparam int NP = 2;
    localparam int AW = 9;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    req_wen;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             sram_en;
    logic             sram_wen;
    logic [AW-1:0]    sram_addr;
    logic [DW-1:0]    sram_wdata;
    logic [DW-1:0]    sram_rdata = '0;

    logic             pl_en = 1'b0;
    logic [AW-1:0]    pl_addr = '0;
    logic [DW-1:0]    pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int en_count = 0;

    sram_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Word-wide SRAM with registered read data, preloadable from the bench.
    bit [DW-1:0] smem [512];
    always @(posedge clk) begin
        if (pl_en) smem[pl_addr] <= pl_data;
        else if (sram_en) begin
            if (sram_wen) smem[sram_addr] <= sram_wdata;
            else          sram_rdata <= smem[sram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NP-1:0] v, input int last);
        for (int i = 1; i <= NP; i++) begin
            if (v[(last + i) % NP]) return (last + i) % NP;
        end
        return -1;
    endfunction

    // Reference model: an accepted request shows sram_en one cycle later and
    // its response two cycles later; no accept is possible the cycle after one.
    typedef struct {
        bit          v;
        int          port;
        bit          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
    } txn_t;

    bit [DW-1:0]   refmem [512];
    txn_t          h1, h2, nt;
    int            m_last = NP - 1;
    int            pk;
    logic [DW-1:0] hold = '0;
    logic [NP-1:0] exp_ready;
    logic          prev_en = 1'b0;

    always @(negedge clk) begin
        if (pl_en) refmem[pl_addr] = pl_data;
        if (reset) begin
            chk("rst_sram_en", 32'(sram_en), 32'd0);
            chk("rst_sram_wen", 32'(sram_wen), 32'd0);
            chk("rst_sram_addr", 32'(sram_addr), 32'd0);
            chk("rst_sram_wdata", sram_wdata, 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            h1.v = 1'b0; h2.v = 1'b0; m_last = NP - 1; hold = '0; prev_en = 1'b0;
        end else begin
            chk("sram_en", 32'(sram_en), 32'(h1.v));
            chk("en_gap", 32'(sram_en && prev_en), 32'd0);
            if (h1.v) begin
                chk("sram_wen", 32'(sram_wen), 32'(h1.wen));
                chk("sram_addr", 32'(sram_addr), 32'(h1.addr));
                if (h1.wen) chk("sram_wdata", sram_wdata, h1.wdata);
            end
            chk("rsp_valid", 32'(rsp_valid), h2.v ? (32'd1 << h2.port) : 32'd0);
            if (h2.v && !h2.wen) hold = h2.rd;
            chk("rsp_rdata", rsp_rdata, hold);
            exp_ready = '0;
            pk = -1;
            if (!h1.v) begin
                pk = rr_pick(req_valid, m_last);
                if (pk >= 0) exp_ready[pk] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            nt.v = 1'b0;
            if (pk >= 0) begin
                nt.v     = 1'b1;
                nt.port  = pk;
                nt.wen   = req_wen[pk];
                nt.addr  = req_addr[pk*AW +: AW];
                nt.wdata = req_wdata[pk*DW +: DW];
                nt.rd    = refmem[nt.addr];
                if (nt.wen) refmem[nt.addr] = nt.wdata;
                m_last = pk;
            end
            if (sram_en) en_count++;
            prev_en = sram_en;
            h2 = h1;
            h1 = nt;
        end
    end

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wen[p]            = w;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        set_port(p, w, a, d);
        req_valid[p] = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[p]) ok = 1'b1;
        end
        chk("issue_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    initial begin
        int g;
        int n_acc;
        int en0;
        bit hit;
        bit ok;
        logic [3:0] order;

        reset = 1'b1; req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
        @(posedge clk); #1;
        preload(9'h005, 32'hDEADBEEF);
        preload(9'h010, 32'hA0A00010);
        preload(9'h020, 32'hB0B00020);
        for (int i = 0; i < 8; i++) preload(AW'(9'h100 + i), 32'h50000000 + 32'(i) * 32'h11);
        reset = 1'b0;

        // Single read
        issue(0, 1'b0, 9'h005, '0);
        @(negedge clk);
        chk("t1_en", 32'(sram_en), 32'd1);
        chk("t1_addr", 32'(sram_addr), 32'h005);
        @(negedge clk);
        chk("t1_rspv", 32'(rsp_valid), 32'b01);
        chk("t1_data", rsp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Write then read on port 1
        issue(1, 1'b1, 9'h1FF, 32'h12345678);
        @(negedge clk);
        chk("t2_wen", 32'(sram_wen), 32'd1);
        @(negedge clk);
        chk("t2_rspv", 32'(rsp_valid), 32'b10);
        chk("t2_hold", rsp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        issue(1, 1'b0, 9'h1FF, '0);
        @(negedge clk); @(negedge clk);
        chk("t2_rspv_rd", 32'(rsp_valid), 32'b10);
        chk("t2_data", rsp_rdata, 32'h12345678);
        @(posedge clk); #1;

        // Contention from reset
        reset = 1'b1;
        set_port(0, 1'b0, 9'h010, '0);
        set_port(1, 1'b0, 9'h020, '0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("t3_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        g = 0; order = '0;
        for (int k = 0; k < 20 && g < 4; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                order[g] = req_ready[1];
                g++;
            end
            @(posedge clk); #1;
            if (g == 4) req_valid = '0;
        end
        chk("t3_grants", 32'(g), 32'd4);
        chk("t3_order", 32'(order), 32'b1010);
        repeat (3) @(posedge clk);
        #1;

        // Streaming on port 0
        set_port(0, 1'b0, 9'h100, '0);
        req_valid[0] = 1'b1;
        n_acc = 0;
        en0 = en_count;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hit = req_ready[0] && req_valid[0];
            if (hit) n_acc++;
            @(posedge clk); #1;
            if (hit) req_addr[0 +: AW] = req_addr[0 +: AW] + 9'd1;
            if (n_acc == 8) req_valid[0] = 1'b0;
        end
        chk("t4_accepts", 32'(n_acc), 32'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_en_pulses", 32'(en_count - en0), 32'd8);

        // Reset during ACCESS
        issue(0, 1'b0, 9'h005, '0);
        chk("t5_en_access", 32'(sram_en), 32'd1);
        set_port(0, 1'b0, 9'h010, '0);
        set_port(1, 1'b0, 9'h020, '0);
        req_valid = 2'b11;
        #2 reset = 1'b1;
        #1;
        chk("t5_en_async", 32'(sram_en), 32'd0);
        chk("t5_rspv_async", 32'(rsp_valid), 32'd0);
        chk("t5_ready_async", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_p0_wins", 32'(req_ready), 32'b01);
        chk("t5_no_rsp0", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t5_no_rsp1", 32'(rsp_valid), 32'd0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (req_ready[1]) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t5_p1_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t5_p1_data", rsp_rdata, 32'hB0B00020);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer in front of the `gf180mcu_sram_512x32` word-wide SRAM wrapper. It accepts independent read/write requests from two requesters (instruction fetch on port 0, load/store on port 1) over valid/ready. It issues each accepted request to the SRAM as a single-cycle `en` pulse and returns a one-cycle response with registered read data to the owning port. The block enforces the wrapper's rule of at most one access every other cycle.

## Interface
- `NPORTS`, 2: number of requesters; the design is exercised at 2.
- `ADDR_W`, 9: word address width.
- `DATA_W`, 32: data width.
- `clk`  in  1  single clock for the block and the SRAM.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NPORTS  per-port request valid.
- `req_ready`  out  NPORTS  per-port request accepted this cycle.
- `req_wen`  in  NPORTS  1 = write, 0 = read.
- `req_addr`  in  NPORTS*ADDR_W  per-port address, packed with port 0 in the LSBs.
- `req_wdata`  in  NPORTS*DATA_W  per-port write data, packed.
- `rsp_valid`  out  NPORTS  one-cycle response pulse to the owning port.
- `rsp_rdata`  out  DATA_W  read data; shared by both ports, qualified by `rsp_valid`.
- `sram_en`  out  1  to wrapper `en`.
- `sram_wen`  out  1  to wrapper `wen`.
- `sram_addr`  out  ADDR_W  to wrapper `addr`.
- `sram_wdata`  out  DATA_W  to wrapper `wdata`.
- `sram_rdata`  in  DATA_W  from wrapper `rdata`.

## Operation
- The FSM has three states: IDLE, ACCESS and CAPTURE. The reset state is IDLE.
- **Accept window.** A request can be accepted only in IDLE or CAPTURE.
  - The round-robin grant picks one valid port. `req_ready[g]` is driven high combinationally for the granted port only.
  - A request is accepted on a cycle where `req_valid & req_ready` is high for that port.
- **On accept:**
  - Register `sram_addr`, `sram_wdata` and `sram_wen` from the granted port.
  - Set `sram_en` to 1 and record the owner and whether the access is a read.
  - Go to ACCESS.
- **ACCESS.** `sram_en` is 1 for exactly this cycle. The SRAM samples at the end of the cycle. Next state is CAPTURE, and `sram_en` returns to 0.
- **CAPTURE:**
  - Pulse `rsp_valid[owner]` for one cycle, for both reads and writes.
  - On a read, load `sram_rdata` into the `rsp_rdata` register.
  - On a write, `rsp_rdata` keeps its previous value.
  - If a new request is accepted in the same cycle, go to ACCESS; otherwise go to IDLE.
- **Round-robin rule:**
  - A pointer holds the last granted port. The next grant searches from last+1 upward, with wrap-around.
  - The pointer updates only on accept. After reset the pointer is `NPORTS-1`, so port 0 wins the first contention.
- **Requester rules:**
  - A requester holds `req_*` stable while valid and not ready.
  - `req_valid` must not depend combinationally on `req_ready`.
  - Responses cannot be backpressured; the requester must take `rsp_valid` when it is pulsed.
- **Boundaries:**
  - Simultaneous valid on both ports: only the round-robin winner sees ready. The loser stays pending and wins the next accept window.
  - A single requester streaming alone is accepted in every CAPTURE, giving one access per 2 cycles.
  - Address 0 and address 511 need no special handling; there is no wrap logic.
- **Reset mid-operation:** asynchronous reset forces IDLE immediately.
  - `sram_en`, `sram_wen`, `req_ready` and `rsp_valid` go to 0.
  - An in-flight response is dropped; a write may or may not have landed.
- **Reset values:**
  - `sram_en` = 0, `sram_wen` = 0, `sram_addr` = 0, `sram_wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0.
  - `req_ready` = 0 while `reset` is high.

## Timing
- Accept at the edge ending cycle T, then `sram_en` = 1 during T+1, then `rsp_valid` and `rsp_rdata` valid during T+2.
- Latency from accept to response is 2 cycles.
- The next accept is possible at the end of T+2, so `sram_en` is never high on two consecutive cycles. This matches the wrapper's `was_en` gap.
- `rsp_rdata` holds its value from CAPTURE until the next read's CAPTURE.
- `req_ready` is a combinational function of the state, `req_valid` and the pointer. All `sram_*` and `rsp_*` outputs are registered.

## Structure
- **Package `sram_arb_pkg`:**
  - State enum: IDLE, ACCESS, CAPTURE.
  - Defaults for `ADDR_W` and `DATA_W`.
  - Port index width `$clog2(NPORTS)`.
- **Sub-module `rr_arbiter`:**
  - Combinational grant from the request vector and the last-grant pointer, with a registered pointer updated on an `advance` input.
  - `sram_arbiter` instantiates it once.
- The SRAM wrapper is instantiated outside this block, at the memory subsystem level.

## Test plan
- **Single read:** preload addr 0x005 = 0xDEADBEEF; port 0 reads 0x005 → `sram_en` pulses for 1 cycle; `rsp_valid[0]` 2 cycles after accept with `rsp_rdata` = 0xDEADBEEF; `rsp_valid[1]` stays 0.
- **Write then read:** port 1 writes 0x1FF ← 0x12345678 → `rsp_valid[1]` pulses and `rsp_rdata` is unchanged; port 1 then reads 0x1FF → 0x12345678.
- **Contention:** both ports valid from reset (port 0 reads 0x010, port 1 reads 0x020) → grants 0, 1, 0, 1 across accept windows; no `sram_en` on consecutive cycles; each `rsp_valid` matches its owner's data.
- **Streaming:** port 0 holds valid for 8 reads of consecutive addresses → 8 accepts in 16 cycles; `sram_en` toggles 1/0; responses arrive in order with correct data.
- **Reset in ACCESS:** assert `reset` asynchronously mid-cycle → `sram_en`, `rsp_valid` and `req_ready` drop to 0 without waiting for a clock edge; no response after release; the next request works and port 0 wins contention.
